// File: rtl/st_rlist_sequencer.sv
// ----------------------------------------------------------------------------
// st_rlist_sequencer
//
// Purpose:
//    Sequences a register-list PUSH or POP into single-word memory accesses.
//    On start, the request (direction, register list and base address) is
//    latched. One memory access is then issued per set bit of the list, in
//    ascending bit order. The stack pointer is updated once, on the final
//    (FINISH) cycle, so an aborted operation never leaves a partial update.
//
// Ports:
//    clk        in   1   clock; all state updates on the rising edge
//    resetn     in   1   asynchronous active-low reset
//    start      in   1   one-cycle request to begin a PUSH or POP (ignored when busy)
//    is_push    in   1   1 = PUSH, 0 = POP; sampled with start
//    rlist      in   9   bits 0-7 = R0-R7, bit 8 = LR (PUSH) / PC (POP)
//    dmem_ack   in   1   memory accepts the current access this cycle
//    dmem_req   out  1   memory access request
//    dmem_wr    out  1   1 = store (PUSH), 0 = load (POP)
//    dmem_addr  out  16  word address of the current access
//    rf_addr    out  3   register-file index of the current access (0 for LR/PC)
//    lr_sel     out  1   current access targets bit 8 (LR on store, PC on load)
//    rf_wr      out  1   POP load of R0-R7 accepted this cycle
//    pc_wr      out  1   POP load of PC accepted this cycle
//    busy       out  1   sequencer not idle
//    done       out  1   one-cycle completion pulse
//    sp_out     out  16  current stack pointer
//    err        out  1   (only with ST_SEQ_EMPTY_ERR_EN) empty-list error pulse
//
// Configuration macro:
//    ST_SEQ_EMPTY_ERR_EN - when defined, a start with an empty register list
//    pulses err instead of done. Otherwise an empty list is a no-op that still
//    pulses done one cycle after start. The stack pointer is unchanged in both
//    cases.
// ----------------------------------------------------------------------------
module st_rlist_sequencer #(
   parameter logic [15:0] SP_INIT   = 16'h0400,
   parameter logic [15:0] ADDR_STEP = 16'd1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        is_push,
   input  logic [8:0]  rlist,
   input  logic        dmem_ack,
   output logic        dmem_req,
   output logic        dmem_wr,
   output logic [15:0] dmem_addr,
   output logic [2:0]  rf_addr,
   output logic        lr_sel,
   output logic        rf_wr,
   output logic        pc_wr,
   output logic        busy,
   output logic        done,
   output logic [15:0] sp_out
`ifdef ST_SEQ_EMPTY_ERR_EN
   ,
   output logic        err
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      FINISH = 2'd2
   } state_t;

   // Number of set bits in a register list, widened to address width so it
   // can be scaled by ADDR_STEP directly.
   function automatic logic [15:0] popcount9(input logic [8:0] v);
      logic [15:0] n;
      n = 16'd0;
      for (int i = 0; i < 9; i++) begin
         n = n + {15'd0, v[i]};
      end
      return n;
   endfunction

   // Index of the lowest set bit among R0-R7; 0 when none are set
   // (the remaining bit is then LR/PC, which has no register-file index).
   function automatic logic [2:0] lowest_reg(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) begin
            idx = 3'(i);
         end
      end
      return idx;
   endfunction

   state_t      state_reg, state_next;
   logic [8:0]  pend_reg,  pend_next;   // bits still to be served
   logic        push_reg,  push_next;
   logic [15:0] base_reg,  base_next;
   logic [15:0] addr_reg,  addr_next;   // address of the next access to issue
   logic [15:0] sp_reg,    sp_next;
`ifdef ST_SEQ_EMPTY_ERR_EN
   logic        empty_reg, empty_next;
`endif

   // Bit 8 is only served once R0-R7 are exhausted, so the current access
   // targets LR/PC exactly when no low bits remain pending.
   logic        cur_lr;
   logic [2:0]  cur_idx;

   assign cur_lr  = (pend_reg[7:0] == 8'd0);
   assign cur_idx = lowest_reg(pend_reg[7:0]);
   assign sp_out  = sp_reg;

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg <= IDLE;
         pend_reg  <= 9'd0;
         push_reg  <= 1'b0;
         base_reg  <= 16'd0;
         addr_reg  <= 16'd0;
         sp_reg    <= SP_INIT;
`ifdef ST_SEQ_EMPTY_ERR_EN
         empty_reg <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         pend_reg  <= pend_next;
         push_reg  <= push_next;
         base_reg  <= base_next;
         addr_reg  <= addr_next;
         sp_reg    <= sp_next;
`ifdef ST_SEQ_EMPTY_ERR_EN
         empty_reg <= empty_next;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      pend_next  = pend_reg;
      push_next  = push_reg;
      base_next  = base_reg;
      addr_next  = addr_reg;
      sp_next    = sp_reg;
`ifdef ST_SEQ_EMPTY_ERR_EN
      empty_next = empty_reg;
      err        = 1'b0;
`endif
      dmem_req   = 1'b0;
      dmem_wr    = 1'b0;
      dmem_addr  = 16'd0;
      rf_addr    = 3'd0;
      lr_sel     = 1'b0;
      rf_wr      = 1'b0;
      pc_wr      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               push_next = is_push;
               pend_next = rlist;
               // PUSH pre-decrements so the block ends just below the old SP;
               // POP reads upward from the current SP.
               if (is_push) begin
                  base_next = sp_reg - popcount9(rlist) * ADDR_STEP;
               end else begin
                  base_next = sp_reg;
               end
               addr_next = base_next;
`ifdef ST_SEQ_EMPTY_ERR_EN
               empty_next = (rlist == 9'd0);
`endif
               state_next = (rlist == 9'd0) ? FINISH : ACCESS;
            end
         end

         ACCESS: begin
            busy      = 1'b1;
            dmem_req  = 1'b1;
            dmem_wr   = push_reg;
            dmem_addr = addr_reg;
            lr_sel    = cur_lr;
            rf_addr   = cur_idx;
            if (dmem_ack) begin
               rf_wr     = ~push_reg & ~cur_lr;
               pc_wr     = ~push_reg &  cur_lr;
               // Clear the lowest pending bit, i.e. the one just served.
               pend_next = pend_reg & (pend_reg - 9'd1);
               addr_next = addr_reg + ADDR_STEP;
               if (pend_next == 9'd0) begin
                  state_next = FINISH;
               end
            end
         end

         FINISH: begin
            busy = 1'b1;
`ifdef ST_SEQ_EMPTY_ERR_EN
            err  = empty_reg;
            done = ~empty_reg;
`else
            done = 1'b1;
`endif
            // After the last access addr_reg sits one step past the block,
            // which is the post-POP stack pointer. For an empty list both
            // choices equal the old SP.
            sp_next    = push_reg ? base_reg : addr_reg;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_st_rlist_sequencer.sv
`timescale 1ns/1ps
module tb_st_rlist_sequencer;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic        is_push = 1'b0;
   logic [8:0]  rlist = 9'd0;
   logic        dmem_ack = 1'b0;
   logic        dmem_req;
   logic        dmem_wr;
   logic [15:0] dmem_addr;
   logic [2:0]  rf_addr;
   logic        lr_sel;
   logic        rf_wr;
   logic        pc_wr;
   logic        busy;
   logic        done;
   logic [15:0] sp_out;
`ifdef ST_SEQ_EMPTY_ERR_EN
   logic        err;
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   st_rlist_sequencer dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .is_push   (is_push),
      .rlist     (rlist),
      .dmem_ack  (dmem_ack),
      .dmem_req  (dmem_req),
      .dmem_wr   (dmem_wr),
      .dmem_addr (dmem_addr),
      .rf_addr   (rf_addr),
      .lr_sel    (lr_sel),
      .rf_wr     (rf_wr),
      .pc_wr     (pc_wr),
      .busy      (busy),
      .done      (done),
      .sp_out    (sp_out)
`ifdef ST_SEQ_EMPTY_ERR_EN
      ,
      .err       (err)
`endif
   );

   // kind: 0 = memory access, 1 = done pulse, 2 = err pulse
   typedef struct {
      int          kind;
      logic        wr;
      logic [15:0] addr;
      logic [2:0]  rfa;
      logic        lr;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          failures = 0;
   bit          mon_en = 1'b0;
   logic [15:0] model_sp = 16'h0400;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Monitor: compares every presented access / completion pulse against the
   // head of the scoreboard. While an access is stalled the head is only
   // peeked, so every stalled cycle re-checks that the request is stable.
   // ------------------------------------------------------------------------
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (dmem_req) begin
            if (sb_q.size() == 0 || sb_q[0].kind != 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_access: got addr %0h, expected no access", dmem_addr);
            end else begin
               e = sb_q[0];
               chk("acc_wr",   32'(dmem_wr),   32'(e.wr));
               chk("acc_addr", 32'(dmem_addr), 32'(e.addr));
               chk("acc_lr",   32'(lr_sel),    32'(e.lr));
               if (!e.lr) chk("acc_rf_addr", 32'(rf_addr), 32'(e.rfa));
               chk("acc_rf_wr", 32'(rf_wr), 32'(dmem_ack & ~e.wr & ~e.lr));
               chk("acc_pc_wr", 32'(pc_wr), 32'(dmem_ack & ~e.wr &  e.lr));
               if (dmem_ack) void'(sb_q.pop_front());
            end
         end else begin
            chk("no_req_strobes", 32'({rf_wr, pc_wr}), 32'd0);
         end
         if (done) begin
            if (sb_q.size() == 0 || sb_q[0].kind != 1) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: got done=1, expected pending done=0");
            end else begin
               chk("done_busy", 32'(busy), 32'd1);
               void'(sb_q.pop_front());
            end
         end
`ifdef ST_SEQ_EMPTY_ERR_EN
         if (err) begin
            if (sb_q.size() == 0 || sb_q[0].kind != 2) begin
               checks++;
               failures++;
               $display("FAIL unexpected_err: got err=1, expected pending err=0");
            end else begin
               void'(sb_q.pop_front());
            end
         end
`endif
      end
   end

   function automatic logic done_or_err();
`ifdef ST_SEQ_EMPTY_ERR_EN
      return done | err;
`else
      return done;
`endif
   endfunction

   // ------------------------------------------------------------------------
   // One PUSH/POP transaction. stall = number of ACCESS cycles with ack low
   // before ack goes high; bogus = fire a conflicting start during busy.
   // ------------------------------------------------------------------------
   task automatic do_op(input bit p, input logic [8:0] r, input int stall, input bit bogus);
      int          n;
      int          k;
      int          cyc;
      int          exp_lat;
      bit          got;
      logic [15:0] base;
      logic [15:0] exp_sp;
      exp_t        e;
      n = 0;
      for (int i = 0; i < 9; i++) n += int'(r[i]);
      base = p ? (model_sp - 16'(n)) : model_sp;
      k = 0;
      for (int i = 0; i < 9; i++) begin
         if (r[i]) begin
            e.kind = 0;
            e.wr   = p;
            e.addr = base + 16'(k);
            e.rfa  = 3'(i);
            e.lr   = (i == 8);
            sb_q.push_back(e);
            k++;
         end
      end
      e.kind = (n == 0 && ERR_EN) ? 2 : 1;
      e.wr = 1'b0; e.addr = 16'd0; e.rfa = 3'd0; e.lr = 1'b0;
      sb_q.push_back(e);
      exp_sp  = p ? base : (base + 16'(n));
      exp_lat = (n == 0) ? 1 : (n + 1 + stall);

      start = 1'b1; is_push = p; rlist = r;
      dmem_ack = (stall == 0);
      cyc = 0; got = 1'b0;
      while (!got && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (bogus && cyc == 1) begin
            start = 1'b1; is_push = ~p; rlist = 9'h0FF;
         end else begin
            start = 1'b0;
         end
         dmem_ack = (stall == 0) || (cyc > stall);
         @(negedge clk);
         if (done_or_err()) got = 1'b1;
      end
      start = 1'b0;
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL op_timeout: got no done after %0d cycles, expected done after %0d", cyc, exp_lat);
      end else begin
         chk("op_latency", 32'(cyc), 32'(exp_lat));
      end
      @(posedge clk); #1;
      chk("op_sp_out", 32'(sp_out), 32'(exp_sp));
      chk("op_idle_busy", 32'(busy), 32'd0);
      model_sp = exp_sp;
      $display("op %s rlist=%03h stall=%0d bogus=%0b latency=%0d sp_out=%04h",
               p ? "PUSH" : "POP ", r, stall, bogus, cyc, sp_out);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_sp"},        32'(sp_out),    32'h0400);
      chk({tag, "_req"},       32'(dmem_req),  32'd0);
      chk({tag, "_wr"},        32'(dmem_wr),   32'd0);
      chk({tag, "_addr"},      32'(dmem_addr), 32'd0);
      chk({tag, "_rf_addr"},   32'(rf_addr),   32'd0);
      chk({tag, "_lr_sel"},    32'(lr_sel),    32'd0);
      chk({tag, "_rf_pc_wr"},  32'({rf_wr, pc_wr}), 32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_done"},      32'(done),      32'd0);
`ifdef ST_SEQ_EMPTY_ERR_EN
      chk({tag, "_err"},       32'(err),       32'd0);
`endif
   endtask

   initial begin
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      resetn = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Basic PUSH/POP with LR/PC
      do_op(1'b1, 9'h103, 0, 1'b0);   // 03FD,03FE,03FF ; sp 03FD
      chk("push103_sp", 32'(sp_out), 32'h03FD);
      do_op(1'b0, 9'h103, 0, 1'b0);   // sp 0400
      chk("pop103_sp", 32'(sp_out), 32'h0400);

      // Stalled access held stable
      do_op(1'b1, 9'h001, 3, 1'b0);   // addr 03FF, latency 5
      do_op(1'b0, 9'h001, 0, 1'b0);

      // Empty register list
      do_op(1'b1, 9'h000, 0, 1'b0);
      do_op(1'b0, 9'h000, 0, 1'b0);
      chk("empty_sp", 32'(sp_out), 32'h0400);

      // Start while busy is ignored
      do_op(1'b1, 9'h0FF, 0, 1'b1);   // sp 03F8
      do_op(1'b0, 9'h0FF, 1, 1'b1);   // sp 0400

      // Sparse list with PC, stalls
      do_op(1'b0, 9'h1AA, 2, 1'b0);   // sp 0405
      do_op(1'b1, 9'h1AA, 0, 1'b0);   // sp 0400

      // Walk SP down to 0001, then exercise wrap-around
      for (int i = 0; i < 113; i++) do_op(1'b1, 9'h1FF, 0, 1'b0);
      do_op(1'b1, 9'h03F, 0, 1'b0);
      chk("walk_sp", 32'(sp_out), 32'h0001);
      do_op(1'b1, 9'h003, 0, 1'b0);   // FFFF, 0000 ; sp FFFF
      chk("wrap_push_sp", 32'(sp_out), 32'hFFFF);
      do_op(1'b0, 9'h003, 0, 1'b0);   // sp 0001

      // Reset in the middle of a POP
      start = 1'b1; is_push = 1'b0; rlist = 9'h0FF; dmem_ack = 1'b1;
      mon_en = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("midreset_busy_before", 32'(busy), 32'd1);
      resetn = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      sb_q.delete();
      @(posedge clk); #1;
      resetn = 1'b1;
      dmem_ack = 1'b0;
      model_sp = 16'h0400;
      mon_en = 1'b1;
      repeat (3) @(posedge clk);   // monitor flags any stray done/access
      #1;
      chk("after_reset_sp", 32'(sp_out), 32'h0400);
      do_op(1'b1, 9'h103, 0, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/st_rlist_sequencer.md
ST_RLIST_SEQUENCER -- requirements
Module: st_rlist_sequencer

Interface
REQ-001 Parameter SP_INIT, 16'h0400, stack pointer value after reset.
REQ-002 Parameter ADDR_STEP, 1, address increment per stacked register, in memory words.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a PUSH or POP.
REQ-006 is_push  input  1  1 = PUSH, 0 = POP; sampled with start.
REQ-007 rlist  input  9  bits 0-7 = R0-R7; bit 8 = LR on PUSH, PC on POP; sampled with start.
REQ-008 dmem_ack  input  1  memory accepts the current access this cycle.
REQ-009 dmem_req  output  1  memory access request.
REQ-010 dmem_wr  output  1  1 = store (PUSH), 0 = load (POP); valid while dmem_req is high.
REQ-011 dmem_addr  output  16  word address of the current access.
REQ-012 rf_addr  output  3  register-file index for the current access.
REQ-013 lr_sel  output  1  current access targets bit 8 (LR on store, PC on load).
REQ-014 rf_wr  output  1  POP load of an R0-R7 register is accepted this cycle.
REQ-015 pc_wr  output  1  POP load of PC is accepted this cycle.
REQ-016 busy  output  1  sequencer is not idle; the pipeline stalls while this is high.
REQ-017 done  output  1  one-cycle pulse when the operation completes.
REQ-018 sp_out  output  16  current stack pointer.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, and FINISH.
REQ-020 IDLE: start=1 latches is_push, rlist, and base; next state is ACCESS, or FINISH if rlist==0.
REQ-021 PUSH base = sp_out - popcount(rlist)*ADDR_STEP; POP base = sp_out; all arithmetic is 16-bit modulo, with wrap-around permitted.
REQ-022 ACCESS serves the set bits in ascending order (bit 0 first, bit 8 last) and places the k-th served bit at base + k*ADDR_STEP.
REQ-023 ACCESS holds dmem_req=1 with dmem_addr, rf_addr, lr_sel, and dmem_wr stable until dmem_ack=1.
REQ-024 On ack, the served bit is cleared; the FSM stays in ACCESS if bits remain, otherwise it goes to FINISH.
REQ-025 rf_wr and pc_wr are combinational and equal to dmem_req & dmem_ack & ~dmem_wr, qualified by lr_sel (pc_wr) or ~lr_sel (rf_wr).
REQ-026 FINISH: done=1 for one cycle; sp_out takes the new value at the FINISH edge (PUSH: base; POP: base + popcount*ADDR_STEP); next state is IDLE.
REQ-027 busy=1 in ACCESS and FINISH; busy=0 in IDLE.
REQ-028 start while busy SHALL be ignored, with no latching and no error.
REQ-029 The minimum latency from start to done is popcount+1 cycles; each cycle of dmem_ack=0 adds one cycle.
REQ-030 dmem_ack while dmem_req=0 SHALL be ignored.

Reset
REQ-031 resetn=0 immediately forces IDLE, sp_out=SP_INIT, and dmem_req, dmem_wr, rf_wr, pc_wr, lr_sel, busy, done=0, and dmem_addr, rf_addr=0.
REQ-032 Reset during ACCESS abandons the operation; sp_out is not partially updated and no done pulse is issued.

Configuration
REQ-033 Macro ST_SEQ_EMPTY_ERR_EN: when defined, an output err (1 bit, reset 0) is added, and start with rlist==0 pulses err for one cycle in place of done, leaving sp_out unchanged.
REQ-034 Without ST_SEQ_EMPTY_ERR_EN, the err port does not exist, and start with rlist==0 produces a no-op that still pulses done after one cycle, leaving sp_out unchanged.

Verification
REQ-035 Reset, then PUSH rlist=9'h103 with dmem_ack tied 1: stores at 03FD (R0), 03FE (R1), 03FF (LR, lr_sel=1); done on cycle 4; sp_out=03FD.
REQ-036 Then POP rlist=9'h103 with dmem_ack tied 1: loads at 03FD, 03FE, 03FF; rf_wr for R0 and R1; pc_wr on the third access; sp_out=0400.
REQ-037 PUSH rlist=9'h001 with dmem_ack low for 3 cycles: dmem_req and addr 03FF are held stable; done appears 5 cycles after start.
REQ-038 sp_out=0001, PUSH rlist=9'h003: accesses at FFFF and 0000; sp_out=FFFF (wrap).
REQ-039 start asserted during busy: ignored; the in-flight operation completes unchanged; resetn low in mid-ACCESS gives sp_out=0400 and all outputs 0.
REQ-040 rlist=0 start: with the macro, err pulses and sp is unchanged; without the macro, done pulses 1 cycle later and sp is unchanged.
